pc_stack_unit: RTL and testbench

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

---
 rtl/pc_stack_unit_if.sv | 30 +++
 rtl/pc_stack_unit.sv | 97 +++++++++
 tb/tb_pc_stack_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pc_stack_unit_if.sv
// Bundle between the fetch controller and pc_stack_unit: next-PC control in,
// current PC and return-address-stack status out.
interface pc_stack_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic              pc_en;
    logic [2:0]        pc_select;
    logic [ADDR_W-1:0] jump_data;
    logic              flush;
    logic [ADDR_W-1:0] imem_addr;
    logic [ADDR_W-1:0] rtn_addr;
    logic [ADDR_W-1:0] ras_top;
    logic [CNT_W-1:0]  ras_count;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_ovf;

    modport master (
        output pc_en, pc_select, jump_data, flush,
        input  imem_addr, rtn_addr, ras_top, ras_count, ras_empty, ras_full, ras_ovf
    );

    modport slave (
        input  pc_en, pc_select, jump_data, flush,
        output imem_addr, rtn_addr, ras_top, ras_count, ras_empty, ras_full, ras_ovf
    );
endinterface

// File: rtl/pc_stack_unit.sv
// Program counter with a circular return-address stack: sequential, branch,
// jump, call/return and hold modes, one-cycle latency, sticky overflow flag.
module pc_stack_unit #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_INC    = 4,
    parameter int                RAS_DEPTH = 4
) (
    input logic CLK,
    input logic RST,
    pc_stack_unit_if.slave bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] SEL_SEQ    = 3'd0;
    localparam logic [2:0] SEL_BRANCH = 3'd1;
    localparam logic [2:0] SEL_JUMP   = 3'd2;
    localparam logic [2:0] SEL_CALL   = 3'd3;
    localparam logic [2:0] SEL_JR     = 3'd4;
    localparam logic [2:0] SEL_RET    = 3'd5;

    logic [ADDR_W-1:0] pc_p0;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] rtn;
    logic [ADDR_W-1:0] top;
    logic [ADDR_W-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  top_idx;
    logic [CNT_W-1:0]  count;
    logic              ovf;
    logic              empty;
    logic              full;
    logic              upd;
    logic              do_push;
    logic              do_pop;

    assign rtn     = pc_p0 + ADDR_W'(PC_INC);
    assign top_idx = wp - PTR_W'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));
    assign top     = empty ? '0 : stack[top_idx];

    // Push/pop only on a normal enabled cycle; reset and flush suppress both.
    assign upd     = !RST && !bus.flush && bus.pc_en;
    assign do_push = upd && (bus.pc_select == SEL_CALL);
    assign do_pop  = upd && (bus.pc_select == SEL_RET) && !empty;

    always_comb begin
        pc_nxt = pc_p0;
        case (bus.pc_select)
            SEL_SEQ:                      pc_nxt = rtn;
            SEL_BRANCH, SEL_JUMP, SEL_JR: pc_nxt = bus.jump_data;
            SEL_CALL:                     pc_nxt = bus.jump_data;
            SEL_RET:                      pc_nxt = empty ? bus.jump_data : top;
            default:                      pc_nxt = pc_p0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_p0 <= RESET_PC;
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.flush) begin
            pc_p0 <= bus.jump_data;
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (bus.pc_en) begin
            pc_p0 <= pc_nxt;
            if (do_push) begin
                wp <= wp + PTR_W'(1);
                // A push onto a full stack overwrites the oldest entry.
                if (full) ovf   <= 1'b1;
                else      count <= count + CNT_W'(1);
            end else if (do_pop) begin
                wp    <= wp - PTR_W'(1);
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage carries no reset; count and wp alone define validity.
    always_ff @(posedge CLK) begin
        if (do_push) stack[wp] <= rtn;
    end

    assign bus.imem_addr = pc_p0;
    assign bus.rtn_addr  = rtn;
    assign bus.ras_top   = top;
    assign bus.ras_count = count;
    assign bus.ras_empty = empty;
    assign bus.ras_full  = full;
    assign bus.ras_ovf   = ovf;
endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench for pc_stack_unit: a queue-based stack model predicts each
// cycle's state, results are popped and compared one cycle after driving.
module tb_pc_stack_unit;
    localparam logic [2:0] SEQ = 3'd0, BR = 3'd1, JMP = 3'd2, CALL = 3'd3,
                           JR = 3'd4, RET = 3'd5, HLD6 = 3'd6, HLD7 = 3'd7;

    logic CLK;
    logic RST;

    pc_stack_unit_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus ();
    pc_stack_unit_if #(.ADDR_W(32), .RAS_DEPTH(4)) bus2 ();

    pc_stack_unit #(.ADDR_W(32), .RESET_PC(32'h0), .PC_INC(4), .RAS_DEPTH(4))
        u_dut (.CLK(CLK), .RST(RST), .bus(bus));

    pc_stack_unit #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_INC(4), .RAS_DEPTH(4))
        u_wrap (.CLK(CLK), .RST(RST), .bus(bus2));

    assign bus2.pc_en     = bus.pc_en;
    assign bus2.pc_select = bus.pc_select;
    assign bus2.jump_data = bus.jump_data;
    assign bus2.flush     = bus.flush;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [31:0] top;
        logic        ovf;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_stk[$];
    logic [31:0] m_pc;
    logic        m_ovf;
    int          n_cmp;
    int          n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic collect();
        exp_t e;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL sb_underflow: got no expected entry, expected one per cycle");
        end else begin
            e = sbq.pop_front();
            chk("pc",    bus.imem_addr, e.pc);
            chk("rtn",   bus.rtn_addr, e.pc + 32'd4);
            chk("count", 32'(bus.ras_count), e.cnt);
            chk("top",   bus.ras_top, e.top);
            chk("empty", 32'(bus.ras_empty), 32'(e.cnt == 0));
            chk("full",  32'(bus.ras_full), 32'(e.cnt == 4));
            chk("ovf",   32'(bus.ras_ovf), 32'(e.ovf));
        end
    endtask

    task automatic step(input logic [2:0] sel, input logic [31:0] jd,
                        input logic en, input logic fl, input logic rs);
        exp_t e;
        bus.pc_select = sel;
        bus.jump_data = jd;
        bus.pc_en     = en;
        bus.flush     = fl;
        RST           = rs;
        if (rs) begin
            m_pc = 32'h0; m_stk.delete(); m_ovf = 1'b0;
        end else if (fl) begin
            m_pc = jd; m_stk.delete(); m_ovf = 1'b0;
        end else if (en) begin
            case (sel)
                SEQ:         m_pc = m_pc + 32'd4;
                BR, JMP, JR: m_pc = jd;
                CALL: begin
                    if (m_stk.size() == 4) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_stk.push_back(m_pc + 32'd4);
                    m_pc = jd;
                end
                RET: m_pc = (m_stk.size() > 0) ? m_stk.pop_back() : jd;
                default: ;
            endcase
        end
        e.pc  = m_pc;
        e.cnt = 32'(m_stk.size());
        e.top = (m_stk.size() > 0) ? m_stk[$] : 32'h0;
        e.ovf = m_ovf;
        sbq.push_back(e);
        @(posedge CLK);
        #1;
        collect();
    endtask

    task automatic go(input logic [2:0] sel, input logic [31:0] jd);
        step(sel, jd, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_pc = 32'h0; m_ovf = 1'b0;
        bus.pc_en = 1'b0; bus.pc_select = SEQ; bus.jump_data = '0; bus.flush = 1'b0;
        RST = 1'b1;

        // Reset with a pending flush and RET, which reset must override.
        step(RET, 32'h55, 1'b1, 1'b1, 1'b1);
        chk("rst_pc",     bus.imem_addr, 32'h0);
        chk("rst_rtn",    bus.rtn_addr, 32'h4);
        chk("rst_empty",  32'(bus.ras_empty), 32'h1);
        chk("rst_top",    bus.ras_top, 32'h0);
        chk("wrap_rst",   bus2.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_rtn",   bus2.rtn_addr, 32'h0);

        go(SEQ, 32'h0);
        chk("wrap_seq", bus2.imem_addr, 32'h0);
        go(SEQ, 32'h0);
        go(SEQ, 32'h0);
        chk("seq3_pc", bus.imem_addr, 32'hC);
        go(SEQ, 32'h0);

        go(CALL, 32'h100);
        chk("call_pc",  bus.imem_addr, 32'h100);
        chk("call_cnt", 32'(bus.ras_count), 32'd1);
        go(SEQ, 32'h0);
        chk("call_seq", bus.imem_addr, 32'h104);
        go(RET, 32'h0);
        chk("ret_pc",  bus.imem_addr, 32'h14);
        chk("ret_cnt", 32'(bus.ras_count), 32'd0);

        go(RET, 32'h40);
        chk("ret_empty_pc",  bus.imem_addr, 32'h40);
        chk("ret_empty_ovf", 32'(bus.ras_ovf), 32'h0);

        go(BR, 32'h1000);
        go(JR, 32'h2000);
        go(HLD6, 32'h3000);
        go(HLD7, 32'h3000);
        chk("hold_pc", bus.imem_addr, 32'h2000);
        go(JMP, 32'h0);

        for (int i = 1; i <= 5; i++) go(CALL, 32'(i) << 8);
        chk("ovf_full", 32'(bus.ras_full), 32'h1);
        chk("ovf_set",  32'(bus.ras_ovf), 32'h1);
        go(RET, 32'h0);
        chk("ovf_ret1", bus.imem_addr, 32'h404);
        go(RET, 32'h0);
        go(RET, 32'h0);
        go(RET, 32'h0);
        chk("ovf_ret4", bus.imem_addr, 32'h104);
        go(RET, 32'h80);
        chk("ovf_ret5", bus.imem_addr, 32'h80);
        chk("ovf_sticky", 32'(bus.ras_ovf), 32'h1);

        go(CALL, 32'h500);
        go(CALL, 32'h600);
        for (int i = 0; i < 3; i++) step(RET, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("stall_pc",  bus.imem_addr, 32'h600);
        chk("stall_cnt", 32'(bus.ras_count), 32'd2);
        step(CALL, 32'h200, 1'b0, 1'b1, 1'b0);
        chk("flush_pc",  bus.imem_addr, 32'h200);
        chk("flush_cnt", 32'(bus.ras_count), 32'd0);
        chk("flush_ovf", 32'(bus.ras_ovf), 32'h0);

        go(CALL, 32'h700);
        step(CALL, 32'h900, 1'b1, 1'b0, 1'b1);
        chk("rst_call_pc",  bus.imem_addr, 32'h0);
        chk("rst_call_cnt", 32'(bus.ras_count), 32'd0);

        for (int i = 0; i < 80; i++) begin
            step(3'($urandom_range(0, 7)), {$urandom_range(0, 255), 4'h0},
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
